// File: rtl/imem_loader.sv
// imem_loader
// Program loader on the instruction memory write port. It receives a framed
// byte stream (LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR checksum),
// packs the data into 32-bit words, and writes them sequentially starting
// at BASE_ADDR. While a load is in progress, or after a failed load, it holds
// the fetch stage stalled.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   load_req            start a session (honoured in IDLE or ERR only)
//   rx_valid, rx_data   byte stream input
//   rx_ready            byte accepted this cycle (combinational state decode)
//   imem_we/addr/wdata  instruction memory write port (registered)
//   cpu_stop            fetch stall (registered), high while busy or in ERR
//   load_done           one-cycle pulse on a successful load
//   load_err            level, high while in ERR
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_stop,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_ERR
    } state_t;

    // Word count limit: the frame may fill memory exactly, not more.
    localparam logic [16:0]       CAPACITY = 17'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t              state_reg,    state_next;
    logic [7:0]          xor_reg,      xor_next;
    logic [1:0]          byte_idx_reg, byte_idx_next;
    logic [ADDR_W-1:0]   word_idx_reg, word_idx_next;
    logic [7:0]          len_lo_reg,   len_lo_next;
    logic [15:0]         len_reg,      len_next;
    logic [23:0]         buf_reg,      buf_next;
    logic                we_reg,       we_next;
    logic [ADDR_W-1:0]   addr_reg,     addr_next;
    logic [31:0]         wdata_reg,    wdata_next;
    logic                stop_reg,     stop_next;
    logic                done_reg,     done_next;
    logic                err_reg,      err_next;

    logic                accept;
    logic [15:0]         len_rx;

    assign rx_ready = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                      (state_reg == S_DATA)   || (state_reg == S_CSUM);
    assign accept   = rx_ready && rx_valid;
    assign len_rx   = {rx_data, len_lo_reg};

    always_comb begin
        state_next    = state_reg;
        xor_next      = xor_reg;
        byte_idx_next = byte_idx_reg;
        word_idx_next = word_idx_reg;
        len_lo_next   = len_lo_reg;
        len_next      = len_reg;
        buf_next      = buf_reg;
        we_next       = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE, S_ERR: begin
                if (load_req) begin
                    state_next    = S_LEN_LO;
                    xor_next      = 8'h00;
                    byte_idx_next = 2'd0;
                    word_idx_next = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_next = rx_data;
                    xor_next    = xor_reg ^ rx_data;
                    state_next  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_next = len_rx;
                    xor_next = xor_reg ^ rx_data;
                    if ({1'b0, len_rx} > CAPACITY) begin
                        state_next = S_ERR;
                    end else if (len_rx == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_next      = xor_reg ^ rx_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        // b3 completes the word; b0..b2 sit in buf_reg
                        // with b0 in the low byte.
                        we_next       = 1'b1;
                        addr_next     = BASE + word_idx_reg;
                        wdata_next    = {rx_data, buf_reg};
                        word_idx_next = word_idx_reg + 1'b1;
                        if ((17'(word_idx_reg) + 17'd1) == {1'b0, len_reg}) begin
                            state_next = S_CSUM;
                        end
                    end else begin
                        buf_next = {rx_data, buf_reg[23:8]};
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == xor_reg) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state so they
        // change in the cycle after the deciding edge.
        stop_next = (state_next != S_IDLE);
        err_next  = (state_next == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            xor_reg      <= 8'h00;
            byte_idx_reg <= 2'd0;
            word_idx_reg <= '0;
            len_lo_reg   <= 8'h00;
            len_reg      <= 16'h0000;
            buf_reg      <= 24'h000000;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h00000000;
            stop_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            xor_reg      <= xor_next;
            byte_idx_reg <= byte_idx_next;
            word_idx_reg <= word_idx_next;
            len_lo_reg   <= len_lo_next;
            len_reg      <= len_next;
            buf_reg      <= buf_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            stop_reg     <= stop_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_stop   = stop_reg;
    assign load_done  = done_reg;
    assign load_err   = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances: dut_a (ADDR_W=10, BASE_ADDR=0)
// and dut_b (ADDR_W=2, BASE_ADDR=3), each with its own input stream.
// Frame-level vectors run from a table; multi-cycle corner cases are
// written out by hand.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        lr_a, rv_a, rr_a, we_a, stop_a, done_a, err_a;
    logic [7:0]  rd_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a;
    logic        lr_b, rv_b, rr_b, we_b, stop_b, done_b, err_b;
    logic [7:0]  rd_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .load_req(lr_a), .rx_valid(rv_a), .rx_data(rd_a),
        .rx_ready(rr_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .cpu_stop(stop_a), .load_done(done_a), .load_err(err_a)
    );

    imem_loader #(.ADDR_W(2), .BASE_ADDR(3)) dut_b (
        .clk(clk), .rst(rst), .load_req(lr_b), .rx_valid(rv_b), .rx_data(rd_b),
        .rx_ready(rr_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .cpu_stop(stop_b), .load_done(done_b), .load_err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Write / done logger, sampled shortly after each rising edge.
    int          wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int          log_addr_a [64];
    int          log_addr_b [64];
    logic [31:0] log_data_a [64];
    logic [31:0] log_data_b [64];

    always begin
        @(posedge clk);
        #2;
        if (we_a && wr_cnt_a < 64) begin
            log_addr_a[wr_cnt_a] = int'(addr_a);
            log_data_a[wr_cnt_a] = wd_a;
            wr_cnt_a++;
        end
        if (we_b && wr_cnt_b < 64) begin
            log_addr_b[wr_cnt_b] = int'(addr_b);
            log_data_b[wr_cnt_b] = wd_b;
            wr_cnt_b++;
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive(input logic sel, input logic lr, input logic rv, input logic [7:0] d);
        if (sel) begin
            lr_b = lr; rv_b = rv; rd_b = d;
        end else begin
            lr_a = lr; rv_a = rv; rd_a = d;
        end
    endtask

    // Entered and left on a falling edge.
    task automatic send_byte(input logic sel, input logic [7:0] b, input logic gaps);
        if (gaps) begin
            drive(sel, 1'b0, 1'b0, 8'h00);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drive(sel, 1'b0, 1'b1, b);
        @(negedge clk);
    endtask

    task automatic start(input logic sel);
        drive(sel, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 8'h00);
        check("stop_after_req", sel ? stop_b : stop_a, 1'b1);
    endtask

    function automatic int wr_of(input logic sel);
        return sel ? wr_cnt_b : wr_cnt_a;
    endfunction
    function automatic int done_of(input logic sel);
        return sel ? done_cnt_b : done_cnt_a;
    endfunction
    function automatic int laddr(input logic sel, input int i);
        return sel ? log_addr_b[i] : log_addr_a[i];
    endfunction
    function automatic logic [31:0] ldata(input logic sel, input int i);
        return sel ? log_data_b[i] : log_data_a[i];
    endfunction

    typedef struct packed {
        logic        sel;    // 0 = dut_a, 1 = dut_b
        logic        gaps;   // random rx_valid gaps
        logic [3:0]  nb;     // bytes in the frame
        logic [95:0] bytes;  // first byte in [95:88]
        logic [1:0]  nw;     // expected writes
        logic [9:0]  a0;
        logic [31:0] d0;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs [7];
    vec_t t;
    int   w0, dn0;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{sel:1'b0, gaps:1'b0, nb:4'd11,
                    bytes:{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h7E,8'h00},
                    nw:2'd2, a0:10'd0, d0:32'h00000013, a1:10'd1, d1:32'h0000006F, done:1'b1, err:1'b0};
        vecs[1] = '{sel:1'b0, gaps:1'b0, nb:4'd11,
                    bytes:{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h6F,8'h00,8'h00,8'h00,8'h7F,8'h00},
                    nw:2'd2, a0:10'd0, d0:32'h00000013, a1:10'd1, d1:32'h0000006F, done:1'b0, err:1'b1};
        vecs[2] = vecs[0];
        vecs[3] = '{sel:1'b1, gaps:1'b0, nb:4'd2, bytes:{8'h05,8'h00,80'h0},
                    nw:2'd0, a0:10'd0, d0:32'h0, a1:10'd0, d1:32'h0, done:1'b0, err:1'b1};
        vecs[4] = '{sel:1'b1, gaps:1'b0, nb:4'd3, bytes:{8'h00,8'h00,8'h00,72'h0},
                    nw:2'd0, a0:10'd0, d0:32'h0, a1:10'd0, d1:32'h0, done:1'b1, err:1'b0};
        vecs[5] = '{sel:1'b1, gaps:1'b0, nb:4'd11,
                    bytes:{8'h02,8'h00,8'h44,8'h33,8'h22,8'h11,8'h0F,8'h0F,8'hA5,8'hA5,8'h46,8'h00},
                    nw:2'd2, a0:10'd3, d0:32'h11223344, a1:10'd0, d1:32'hA5A50F0F, done:1'b1, err:1'b0};
        vecs[6] = vecs[5];
        vecs[6].gaps = 1'b1;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("reset_outputs_a", {rr_a, we_a, addr_a, wd_a, stop_a, done_a, err_a}, 64'h0);
        check("reset_outputs_b", {rr_b, we_b, addr_b, wd_b, stop_b, done_b, err_b}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Frame-level table
        for (int v = 0; v < 7; v++) begin
            t   = vecs[v];
            w0  = wr_of(t.sel);
            dn0 = done_of(t.sel);
            start(t.sel);
            for (int i = 0; i < 12; i++) begin
                if (i < int'(t.nb)) send_byte(t.sel, t.bytes[95-8*i -: 8], t.gaps);
            end
            drive(t.sel, 1'b0, 1'b0, 8'h00);
            repeat (3) @(negedge clk);
            $display("vector %0d", v);
            check("vec_writes", 64'(wr_of(t.sel) - w0), 64'(t.nw));
            if (t.nw > 0) begin
                check("vec_addr0", 64'(laddr(t.sel, w0)), 64'(t.a0));
                check("vec_data0", ldata(t.sel, w0), t.d0);
            end
            if (t.nw > 1) begin
                check("vec_addr1", 64'(laddr(t.sel, w0 + 1)), 64'(t.a1));
                check("vec_data1", ldata(t.sel, w0 + 1), t.d1);
            end
            check("vec_done", 64'(done_of(t.sel) - dn0), 64'(t.done));
            check("vec_err", t.sel ? err_b : err_a, t.err);
            check("vec_stop", t.sel ? stop_b : stop_a, t.err);
        end

        // load_req together with rx_valid in IDLE: byte 05 must not be taken
        dn0 = done_cnt_a;
        w0  = wr_cnt_a;
        drive(1'b0, 1'b1, 1'b1, 8'h05);
        @(negedge clk);
        check("req_valid_ready", rr_a, 1'b1);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("req_valid_done", 64'(done_cnt_a - dn0), 64'd1);
        check("req_valid_nowr", 64'(wr_cnt_a - w0), 64'd0);
        check("req_valid_stop", stop_a, 1'b0);

        // Ignored load_req in DATA, plus write / done timing
        dn0 = done_cnt_a;
        start(1'b0);
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h13, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        @(negedge clk);
        send_byte(1'b0, 8'h00, 1'b0);
        check("w0_we", we_a, 1'b1);
        check("w0_addr", addr_a, 10'd0);
        check("w0_data", wd_a, 32'h00000013);
        send_byte(1'b0, 8'h6F, 1'b0);
        check("w0_we_low", we_a, 1'b0);
        check("w0_hold", {addr_a, wd_a}, {10'd0, 32'h00000013});
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        check("w1_we", we_a, 1'b1);
        check("w1_word", {addr_a, wd_a}, {10'd1, 32'h0000006F});
        drive(1'b0, 1'b0, 1'b1, 8'h7E);
        check("stop_before_csum", stop_a, 1'b1);
        check("done_before_csum", done_a, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("done_pulse", done_a, 1'b1);
        check("stop_fall", stop_a, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done_a, 1'b0);
        check("ign_req_done_cnt", 64'(done_cnt_a - dn0), 64'd1);

        // Reset in the middle of a frame
        w0 = wr_cnt_a;
        start(1'b0);
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h13, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {rr_a, we_a, addr_a, wd_a, stop_a, done_a, err_a}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(1'b0, 8'h00, 1'b0);
        check("post_reset_not_ready", rr_a, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h6F, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("post_reset_nowr", 64'(wr_cnt_a - w0), 64'd0);
        check("post_reset_stop", stop_a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
